// File: rtl/riscv_cache_maint_seq_pkg.sv
// Shared cache definitions: geometry helpers and maintenance sequencer enums.
package riscv_cache_maint_seq_pkg;

  function automatic int no_of_sets(input int size_kb, input int block_size, input int ways);
    return (size_kb * 1024 * 8) / (block_size * ways);
  endfunction

  // Never returns 0 so a single-set cache still gets a legal index vector.
  function automatic int no_of_index_bits(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  function automatic int no_of_block_offset_bits(input int block_size);
    return (block_size > 8) ? $clog2(block_size / 8) : 0;
  endfunction

  function automatic int no_of_tag_bits(input int xlen, input int size_kb,
                                        input int block_size, input int ways);
    return xlen - no_of_index_bits(no_of_sets(size_kb, block_size, ways))
                - no_of_block_offset_bits(block_size);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_EVICT,
    ST_CLEAR,
    ST_DONE
  } maint_state_e;

  typedef enum logic {
    MODE_INV,
    MODE_FLUSH
  } maint_mode_e;

endpackage

// File: rtl/riscv_cache_maint_seq_way_pick.sv
// Lowest-set-bit one-hot priority encoder across cache ways, with an empty flag.
module riscv_cache_way_pick #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-1:0] req_i,
  output logic [WAYS-1:0] onehot_o,
  output logic            none_o
);

  // x & -x isolates the lowest set bit.
  assign onehot_o = req_i & (~req_i + WAYS'(1));
  assign none_o   = ~|req_i;

endmodule

// File: rtl/riscv_cache_maint_seq.sv
// Cache invalidate/flush sequencer: stalls the core, walks every set, evicts
// dirty lines on flush, then clears all ways. Passes the core index when idle.
module riscv_cache_maint_seq
  import riscv_cache_maint_seq_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int SIZE       = 64,
  parameter  int BLOCK_SIZE = XLEN,
  parameter  int WAYS       = 2,
  localparam int SETS       = no_of_sets(SIZE, BLOCK_SIZE, WAYS),
  localparam int IDX_BITS   = no_of_index_bits(SETS)
) (
  input  logic                rst_ni,
  input  logic                clk_i,
  input  logic                invalidate_i,
  input  logic                flush_i,
  input  logic [IDX_BITS-1:0] core_idx_i,
  output logic [IDX_BITS-1:0] idx_o,
  output logic                busy_o,
  output logic                stall_o,
  output logic                done_o,
  input  logic [WAYS-1:0]     tag_valid_i,
  input  logic [WAYS-1:0]     tag_dirty_i,
  output logic                tag_we_o,
  output logic [WAYS-1:0]     tag_way_o,
  output logic                evict_req_o,
  output logic [IDX_BITS-1:0] evict_idx_o,
  output logic [WAYS-1:0]     evict_way_o,
  input  logic                evict_ack_i
);

  localparam logic [IDX_BITS-1:0] LAST_SET = IDX_BITS'(SETS - 1);

  maint_state_e        state_q;
  maint_mode_e         mode_q;
  logic [IDX_BITS-1:0] cnt_q;
  logic [WAYS-1:0]     pend_q, pend_d;
  logic [WAYS-1:0]     way_nxt;
  logic                pend_none;
  logic                busy_q, done_q, tag_we_q, evict_req_q;
  logic [WAYS-1:0]     tag_way_q, evict_way_q;
  logic [IDX_BITS-1:0] evict_idx_q;

  // In CHECK the pending set comes straight off the tag read; in EVICT it is
  // the current set minus the way being acknowledged.
  assign pend_d = (state_q == ST_CHECK) ? (tag_valid_i & tag_dirty_i)
                                        : (pend_q & ~evict_way_q);

  riscv_cache_way_pick #(.WAYS(WAYS)) u_way_pick (
    .req_i    (pend_d),
    .onehot_o (way_nxt),
    .none_o   (pend_none)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_INV;
      cnt_q       <= '0;
      pend_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tag_we_q    <= 1'b0;
      tag_way_q   <= '0;
      evict_req_q <= 1'b0;
      evict_idx_q <= '0;
      evict_way_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_i || invalidate_i) begin
            mode_q  <= flush_i ? MODE_FLUSH : MODE_INV;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: state_q <= ST_CHECK;
        ST_CHECK: begin
          pend_q <= pend_d;
          if (mode_q == MODE_FLUSH && !pend_none) begin
            evict_req_q <= 1'b1;
            evict_idx_q <= cnt_q;
            evict_way_q <= way_nxt;
            state_q     <= ST_EVICT;
          end else begin
            tag_we_q  <= 1'b1;
            tag_way_q <= '1;
            state_q   <= ST_CLEAR;
          end
        end
        ST_EVICT: begin
          // Request and way stay frozen until the BIU acknowledges.
          if (evict_ack_i) begin
            pend_q <= pend_d;
            if (!pend_none) begin
              evict_way_q <= way_nxt;
            end else begin
              evict_req_q <= 1'b0;
              evict_way_q <= '0;
              tag_we_q    <= 1'b1;
              tag_way_q   <= '1;
              state_q     <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          tag_we_q  <= 1'b0;
          tag_way_q <= '0;
          if (cnt_q == LAST_SET) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q + IDX_BITS'(1);
            state_q <= ST_READ;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idx_o       = (state_q == ST_IDLE) ? core_idx_i : cnt_q;
  assign busy_o      = busy_q;
  assign stall_o     = busy_q;
  assign done_o      = done_q;
  assign tag_we_o    = tag_we_q;
  assign tag_way_o   = tag_way_q;
  assign evict_req_o = evict_req_q;
  assign evict_idx_o = evict_idx_q;
  assign evict_way_o = evict_way_q;

endmodule

// File: tb/tb_riscv_cache_maint_seq.sv
// Directed bench for riscv_cache_maint_seq: 16-set, 2-way config with a
// behavioural tag memory and a delayed-ack eviction responder.
module tb_riscv_cache_maint_seq;

  localparam int NS = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       invalidate_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [3:0] core_idx_i = '0;
  logic [3:0] idx_o;
  logic       busy_o, stall_o, done_o;
  logic [1:0] tag_valid_i = '0;
  logic [1:0] tag_dirty_i = '0;
  logic       tag_we_o;
  logic [1:0] tag_way_o;
  logic       evict_req_o;
  logic [3:0] evict_idx_o;
  logic [1:0] evict_way_o;
  logic       evict_ack_i = 1'b0;

  riscv_cache_maint_seq #(
    .XLEN(32), .SIZE(1), .BLOCK_SIZE(256), .WAYS(2)
  ) dut (
    .rst_ni(rst_ni), .clk_i(clk_i), .invalidate_i(invalidate_i), .flush_i(flush_i),
    .core_idx_i(core_idx_i), .idx_o(idx_o), .busy_o(busy_o), .stall_o(stall_o),
    .done_o(done_o), .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i),
    .tag_we_o(tag_we_o), .tag_way_o(tag_way_o), .evict_req_o(evict_req_o),
    .evict_idx_o(evict_idx_o), .evict_way_o(evict_way_o), .evict_ack_i(evict_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d exp %0d", tag, got, exp);
  endtask

  // Tag memory with one-cycle registered read; writes clear the selected ways.
  logic [1:0] mv[NS];
  logic [1:0] md[NS];

  always @(posedge clk_i) begin
    tag_valid_i <= mv[idx_o];
    tag_dirty_i <= md[idx_o];
    if (tag_we_o) begin
      mv[idx_o] = mv[idx_o] & ~tag_way_o;
      md[idx_o] = md[idx_o] & ~tag_way_o;
    end
  end

  task automatic mem_clean();
    for (int i = 0; i < NS; i++) begin
      mv[i] = 2'b11;
      md[i] = 2'b00;
    end
  endtask

  function automatic int mem_or_v();
    int r = 0;
    for (int i = 0; i < NS; i++) r |= int'(mv[i]);
    return r;
  endfunction

  function automatic int mem_or_d();
    int r = 0;
    for (int i = 0; i < NS; i++) r |= int'(md[i]);
    return r;
  endfunction

  // Monitor plus eviction responder; ack fires ack_dly cycles after req is seen.
  int   ack_dly = 0, wcnt = 0;
  int   clr_exp = 0, clr_n = 0, clr_bad = 0, hold_bad = 0, done_n = 0;
  bit   any_ev = 0;
  int   ev_log[$];
  logic       prev_req = 1'b0;
  logic [1:0] prev_way = '0;
  logic [3:0] prev_idx = '0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      evict_ack_i = 1'b0;
      wcnt = 0;
      prev_req = 1'b0;
    end else begin
      if (tag_we_o) begin
        if (tag_way_o != 2'b11 || int'(idx_o) != clr_exp) clr_bad++;
        clr_exp++;
        clr_n++;
      end
      if (done_o) done_n++;
      if (evict_req_o) begin
        any_ev = 1;
        if (prev_req && !evict_ack_i &&
            (evict_way_o != prev_way || evict_idx_o != prev_idx)) hold_bad++;
      end
      prev_req = evict_req_o;
      prev_way = evict_way_o;
      prev_idx = evict_idx_o;
      evict_ack_i = 1'b0;
      if (evict_req_o) begin
        if (wcnt == ack_dly) begin
          evict_ack_i = 1'b1;
          wcnt = 0;
          ev_log.push_back(int'(evict_idx_o) * 4 + int'(evict_way_o));
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic clr_logs();
    clr_exp = 0; clr_n = 0; clr_bad = 0; hold_bad = 0; done_n = 0; any_ev = 0;
    ev_log.delete();
  endtask

  // cyc = number of rising edges from the one sampling the request to done_o.
  task automatic run(input logic f, input logic iv, input bit poke_busy,
                     input bit poke_done, output int cyc);
    clr_logs();
    @(negedge clk_i);
    flush_i = f;
    invalidate_i = iv;
    @(negedge clk_i);
    flush_i = 1'b0;
    invalidate_i = 1'b0;
    cyc = 1;
    chk("busy_rise", int'(busy_o), 1);
    chk("stall_rise", int'(stall_o), 1);
    while (!done_o && cyc < 2000) begin
      @(negedge clk_i);
      cyc++;
      flush_i = poke_busy && (cyc == 10);
    end
    flush_i = poke_done;
    @(negedge clk_i);
    flush_i = 1'b0;
    if (poke_done) chk("done_req_ign", int'(busy_o), 0);
    repeat (4) @(negedge clk_i);
  endtask

  int cyc;

  initial begin
    mem_clean();
    core_idx_i = 4'd5;
    #12;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_stall", int'(stall_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_tag_we", int'(tag_we_o), 0);
    chk("rst_tag_way", int'(tag_way_o), 0);
    chk("rst_evict_req", int'(evict_req_o), 0);
    chk("rst_evict_way", int'(evict_way_o), 0);
    chk("rst_evict_idx", int'(evict_idx_o), 0);
    chk("rst_idx", int'(idx_o), 5);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle pass-through
    repeat (6) begin
      @(negedge clk_i);
      chk("idle_idx", int'(idx_o), 5);
      chk("idle_busy", int'(busy_o), 0);
    end
    core_idx_i = 4'd12;
    #1 chk("idle_idx_comb", int'(idx_o), 12);

    // Invalidate, all clean
    mem_clean();
    ack_dly = 0;
    run(1'b0, 1'b1, 1'b0, 1'b0, cyc);
    chk("inv_latency", cyc, 49);
    chk("inv_clr_n", clr_n, 16);
    chk("inv_clr_order", clr_bad, 0);
    chk("inv_no_evict", int'(any_ev), 0);
    chk("inv_done_n", done_n, 1);
    chk("inv_mem_v", mem_or_v(), 0);

    // Flush, set 3 both ways dirty, ack after 4 cycles each
    mem_clean();
    md[3] = 2'b11;
    ack_dly = 4;
    run(1'b1, 1'b0, 1'b0, 1'b0, cyc);
    chk("fl_latency", cyc, 59);
    chk("fl_ev_n", ev_log.size(), 2);
    if (ev_log.size() == 2) begin
      chk("fl_ev0", ev_log[0], 3 * 4 + 1);
      chk("fl_ev1", ev_log[1], 3 * 4 + 2);
    end
    chk("fl_hold", hold_bad, 0);
    chk("fl_clr_n", clr_n, 16);
    chk("fl_clr_order", clr_bad, 0);
    chk("fl_mem_d", mem_or_d(), 0);
    chk("fl_done_n", done_n, 1);

    // Invalidate with dirty lines: dirty ignored
    mem_clean();
    md[2] = 2'b01;
    md[9] = 2'b11;
    ack_dly = 0;
    run(1'b0, 1'b1, 1'b0, 1'b0, cyc);
    chk("invd_latency", cyc, 49);
    chk("invd_no_evict", int'(any_ev), 0);
    chk("invd_clr_order", clr_bad, 0);
    chk("invd_mem_v", mem_or_v(), 0);

    // Both requests together: flush wins; extra flush while busy and in DONE ignored
    mem_clean();
    md[5] = 2'b10;
    mv[6] = 2'b10;
    md[6] = 2'b01;
    ack_dly = 0;
    run(1'b1, 1'b1, 1'b1, 1'b1, cyc);
    chk("both_latency", cyc, 50);
    chk("both_ev_n", ev_log.size(), 1);
    if (ev_log.size() == 1) chk("both_ev0", ev_log[0], 5 * 4 + 2);
    chk("both_done_n", done_n, 1);
    chk("both_clr_n", clr_n, 16);

    // Reset during eviction of set 7
    mem_clean();
    md[7] = 2'b01;
    ack_dly = 1000;
    clr_logs();
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    cyc = 0;
    while (!(evict_req_o && evict_idx_o == 4'd7) && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("rs_reach_evict", int'(cyc < 200), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rs_evict_req", int'(evict_req_o), 0);
    chk("rs_busy", int'(busy_o), 0);
    chk("rs_stall", int'(stall_o), 0);
    chk("rs_tag_we", int'(tag_we_o), 0);
    chk("rs_evict_idx", int'(evict_idx_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    core_idx_i = 4'd9;
    repeat (4) begin
      @(negedge clk_i);
      chk("rs_idx_pass", int'(idx_o), 9);
    end
    chk("rs_no_done", done_n, 0);
    ack_dly = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
